// File: rtl/iopmp_cfg_pkg.sv
// Shared constants for the IOPMP configuration master.
// Holds the register offsets inside the IOPMP config window, the command
// type encodings, the AHB-Lite HTRANS/HSIZE/HRESP/HPROT constants and the
// FSM state enum.
package iopmp_cfg_pkg;

  // Register offsets relative to the IOPMP config window base
  localparam logic [31:0] OFF_SRCID      = 32'h0000_0000;
  localparam logic [31:0] OFF_SRCMD_DATA = 32'h0000_0004;
  localparam logic [31:0] OFF_MD_SEL     = 32'h0000_0008;
  localparam logic [31:0] OFF_INTR_CLEAR = 32'h0000_000C;

  // Command type encodings; 4..7 are illegal
  localparam logic [2:0] CMD_SRCMD      = 3'd0;
  localparam logic [2:0] CMD_MD_SEL     = 3'd1;
  localparam logic [2:0] CMD_MD_ENTRY   = 3'd2;
  localparam logic [2:0] CMD_INTR_CLEAR = 3'd3;

  // AHB-Lite constants
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [3:0] HPROT_CFG     = 4'b0011;  // privileged data access

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/iopmp_cfg_master.sv
// IOPMP configuration master.
// Turns simple configuration commands into single, non-pipelined AHB-Lite
// write transfers into the IOPMP config window, and can autonomously clear
// the IOPMP deny interrupt. Also counts rising edges of the deny interrupt.
//
// Ports:
//   hclk, hrst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake: a command transfers on the
//                         rising edge where both are 1. cmd_ready depends
//                         only on FSM state, hrst, auto_clr_en and intr,
//                         never on cmd_valid.
//   cmd_type/id/ms32/index/data  command fields, sampled on acceptance
//   rsp_valid, rsp_err    one-cycle completion pulse and its error flag
//   auto_clr_en, intr     autonomous interrupt clear enable, deny interrupt
//   deny_cnt              saturating count of intr rising edges
//   hsel..hwdata, hready, hresp   AHB-Lite master port
//   fsm_state             current FSM state (debug observation)
module iopmp_cfg_master
  import iopmp_cfg_pkg::*;
#(
  parameter logic [31:0] IOPMP_BASE    = 32'h4002_0000,
  parameter logic [31:0] MD_ENTRY_BASE = 32'h4002_03A0,
  parameter int unsigned MD_ENTRY_MAX  = 531
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic [15:0] cmd_id,
  input  logic        cmd_ms32,
  input  logic [9:0]  cmd_index,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  input  logic        auto_clr_en,
  input  logic        intr,
  output logic [15:0] deny_cnt,
  output logic        hsel,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  output logic [1:0]  fsm_state
);

  state_e      state;
  logic [2:0]  type_q;
  logic [15:0] id_q;
  logic        ms32_q;
  logic [9:0]  index_q;
  logic [31:0] data_q;
  logic        second_q;  // SRCMD: SRCID write done, SRCMD_DATA write in progress
  logic        err_q;
  logic        auto_q;    // current transfer is an autonomous interrupt clear
  logic        intr_q;

  logic        auto_pend;
  logic        cmd_illegal;
  logic        in_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  assign auto_pend   = auto_clr_en && intr;
  assign cmd_ready   = (state == ST_IDLE) && !hrst && !auto_pend;
  assign cmd_illegal = (cmd_type > CMD_INTR_CLEAR) ||
                       ((cmd_type == CMD_MD_ENTRY) && ({22'b0, cmd_index} > MD_ENTRY_MAX));

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state    <= ST_IDLE;
      type_q   <= '0;
      id_q     <= '0;
      ms32_q   <= 1'b0;
      index_q  <= '0;
      data_q   <= '0;
      second_q <= 1'b0;
      err_q    <= 1'b0;
      auto_q   <= 1'b0;
      intr_q   <= 1'b0;
      deny_cnt <= '0;
    end else begin
      // Deny counter runs regardless of what the FSM is doing
      intr_q <= intr;
      if (intr && !intr_q && (deny_cnt != 16'hFFFF)) begin
        deny_cnt <= deny_cnt + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (auto_pend) begin
            // Interrupt clear wins over any waiting command
            type_q   <= CMD_INTR_CLEAR;
            data_q   <= '0;
            second_q <= 1'b0;
            err_q    <= 1'b0;
            auto_q   <= 1'b1;
            state    <= ST_ADDR;
          end else if (cmd_valid) begin
            type_q   <= cmd_type;
            id_q     <= cmd_id;
            ms32_q   <= cmd_ms32;
            index_q  <= cmd_index;
            data_q   <= cmd_data;
            second_q <= 1'b0;
            auto_q   <= 1'b0;
            err_q    <= cmd_illegal;
            // Illegal commands report an error without touching the bus
            state    <= cmd_illegal ? ST_RESP : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (hready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (hready) begin
            if (hresp == HRESP_ERROR) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else if ((type_q == CMD_SRCMD) && !second_q) begin
              second_q <= 1'b1;
              state    <= ST_ADDR;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_addr = IOPMP_BASE;
    case (type_q)
      CMD_SRCMD:      wr_addr = IOPMP_BASE + (second_q ? OFF_SRCMD_DATA : OFF_SRCID);
      CMD_MD_SEL:     wr_addr = IOPMP_BASE + OFF_MD_SEL;
      CMD_MD_ENTRY:   wr_addr = MD_ENTRY_BASE + {20'b0, index_q, 2'b00};
      CMD_INTR_CLEAR: wr_addr = IOPMP_BASE + OFF_INTR_CLEAR;
      default:        wr_addr = IOPMP_BASE;
    endcase
  end

  always_comb begin
    wr_data = data_q;
    if ((type_q == CMD_SRCMD) && !second_q) begin
      wr_data = {ms32_q, 15'b0, id_q};
    end else if (type_q == CMD_INTR_CLEAR) begin
      wr_data = '0;
    end
  end

  assign in_addr   = (state == ST_ADDR);
  assign hsel      = in_addr;
  assign htrans    = in_addr ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite    = in_addr;
  assign hsize     = in_addr ? HSIZE_WORD : 3'b000;
  assign hprot     = in_addr ? HPROT_CFG : 4'b0000;
  assign haddr     = in_addr ? wr_addr : 32'h0;
  assign hwdata    = (state == ST_DATA) ? wr_data : 32'h0;

  assign rsp_valid = (state == ST_RESP) && !auto_q;
  assign rsp_err   = rsp_valid && err_q;
  assign fsm_state = state;

endmodule

// File: doc/iopmp_cfg_master.md
IOPMP_CFG_MASTER -- requirements
Module: iopmp_cfg_master

Interface
REQ-001 Parameter IOPMP_BASE, 32'h40020000, base of the IOPMP config window; SRCID +0x0, SRCMD_DATA +0x4, MD_SEL +0x8, INTR_CLEAR +0xC.
REQ-002 Parameter MD_ENTRY_BASE, 32'h400203A0, address of MD entry index 0; entry n at MD_ENTRY_BASE+4n.
REQ-003 Parameter MD_ENTRY_MAX, 531, highest legal MD entry index.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 hclk  in  1  clock, all logic on rising edge.
REQ-006 hrst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-009 cmd_type  in  3  0=SRCMD, 1=MD_SEL, 2=MD_ENTRY, 3=INTR_CLEAR, 4-7 illegal.
REQ-010 cmd_id  in  16  source ID (SRCMD only).
REQ-011 cmd_ms32  in  1  SRCMD MS32 flag, driven on hwdata[31] of the SRCID write.
REQ-012 cmd_index  in  10  MD entry index (MD_ENTRY only).
REQ-013 cmd_data  in  32  write data.
REQ-014 rsp_valid  out  1  one-cycle completion pulse; rsp_err  out  1  error flag, valid with rsp_valid.
REQ-015 auto_clr_en  in  1  enable autonomous interrupt clear; intr  in  1  IOPMP deny interrupt.
REQ-016 deny_cnt  out  16  saturating count of intr rising edges.
REQ-017 AHB master outputs: hsel 1, haddr 32, htrans 2, hwrite 1, hsize 3, hprot 4, hwdata 32; inputs: hready 1, hresp 2.

Function
REQ-018 SHALL issue only single non-pipelined writes: address phase htrans=2'b10, hsel=1, hwrite=1, hsize=3'b010, hprot=4'b0011; htrans=2'b00, hsel=0, hwrite=0 otherwise.
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, RESP; cmd_ready=1 only in IDLE with no auto-clear pending.
REQ-020 On accept, command fields SHALL be registered; next state ADDR (legal) or RESP with rsp_err=1 and no bus activity (illegal type, or MD_ENTRY with cmd_index>MD_ENTRY_MAX).
REQ-021 ADDR SHALL hold address-phase signals until hready=1, then go to DATA.
REQ-022 DATA SHALL drive hwdata stable until hready=1; hresp=2'b01 at hready SHALL abort remaining writes, go to RESP with rsp_err=1.
REQ-023 SRCMD SHALL be two writes: SRCID with hwdata={cmd_ms32,15'b0,cmd_id}, then SRCMD_DATA with cmd_data; other legal types one write with cmd_data (INTR_CLEAR data 0).
REQ-024 Zero-wait latency: single write accept T, ADDR T+1, DATA T+2, rsp_valid T+3, cmd_ready T+4; SRCMD rsp_valid T+5.
REQ-025 Wait states SHALL extend the current phase one cycle per hready=0 cycle.
REQ-026 When auto_clr_en=1 and intr=1 in IDLE, an INTR_CLEAR write SHALL take priority over cmd_valid (cmd_ready=0); it passes through RESP without rsp_valid.
REQ-027 deny_cnt SHALL increment on each 0->1 of intr (registered copy), saturate at 16'hFFFF, independent of FSM state.
REQ-028 rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-029 hrst=1 SHALL force IDLE in the same edge, abandoning any transfer mid-phase; all outputs 0 (htrans=IDLE, hsel=0), deny_cnt=0, registered intr=0.
REQ-030 cmd_ready SHALL be 0 while hrst=1 and 1 the first cycle after release (absent auto-clear).

Structure
REQ-031 Package iopmp_cfg_pkg SHALL hold register offsets, cmd_type encodings, HTRANS/HSIZE/HRESP constants and the FSM state enum.
REQ-032 Single flat module; no sub-module; target 150-300 lines.

Verification
REQ-033 MD_SEL cmd_data=5, hready=1 -> haddr=40020008 at T+1, hwdata=5 at T+2, rsp_valid T+3, rsp_err=0.
REQ-034 SRCMD id=16'h0003, ms32=1, data=32'hA5A5A5A5 -> writes 40020000/80000003 then 40020004/A5A5A5A5, rsp_valid T+5.
REQ-035 MD_ENTRY index=531 -> haddr=40020BEC; index=532 -> no htrans NONSEQ, rsp_valid T+1 with rsp_err=1.
REQ-036 hready=0 for 3 cycles in DATA, then hresp=2'b01 on SRCID write -> hwdata stable, no SRCMD_DATA write, rsp_err=1.
REQ-037 auto_clr_en=1, intr rises while cmd_valid=1 -> INTR_CLEAR write to 4002000C first, deny_cnt=1, then command accepted.
REQ-038 hrst pulse during ADDR -> next cycle htrans=0, hsel=0, cmd_ready=1 after release, deny_cnt=0.
